// File: rtl/ibex_noc_tx_pkg.sv
// Shared types for the outbound NoC transmit path of an Ibex hart.
// Holds the transmit FSM encoding, the buffered message record and the
// header flit field positions, plus a helper that assembles a header flit.
package ibex_noc_tx_pkg;

  typedef enum logic [1:0] {
    NocTxIdle,
    NocTxHeader,
    NocTxPayload
  } noc_tx_state_e;

  // One complete message as buffered between the core and the link.
  // data[0] is sent first; len is the number of payload words minus one.
  typedef struct packed {
    logic [4:0]       core;
    logic [4:0]       addr;
    logic [1:0]       len;
    logic [3:0][31:0] data;
  } noc_msg_t;

  localparam int unsigned HdrCoreLsb = 27;
  localparam int unsigned HdrAddrLsb = 22;
  localparam int unsigned HdrLenLsb  = 20;
  localparam int unsigned HdrSrcLsb  = 15;

  function automatic logic [31:0] noc_header(noc_msg_t msg, logic [4:0] src);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HdrCoreLsb +: 5] = msg.core;
    hdr[HdrAddrLsb +: 5] = msg.addr;
    hdr[HdrLenLsb  +: 2] = msg.len;
    hdr[HdrSrcLsb  +: 5] = src;
    return hdr;
  endfunction

endpackage

// File: rtl/ibex_noc_tx_if.sv
// Core-side message port of the NoC transmitter.
// master: the core (drives request and message fields, receives grant).
// slave : the transmitter (receives request and fields, drives grant).
interface ibex_noc_tx_if;
  logic        noc_req;
  logic        noc_gnt;
  logic [1:0]  len;
  logic [31:0] output_data;
  logic [31:0] msg1_data;
  logic [31:0] msg2_data;
  logic [31:0] msg3_data;
  logic [4:0]  output_addr;
  logic [4:0]  output_core;

  modport master (
    output noc_req, len, output_data, msg1_data, msg2_data, msg3_data,
           output_addr, output_core,
    input  noc_gnt
  );

  modport slave (
    input  noc_req, len, output_data, msg1_data, msg2_data, msg3_data,
           output_addr, output_core,
    output noc_gnt
  );
endinterface

// File: rtl/ibex_noc_msg_fifo.sv
// Synchronous message FIFO for the NoC transmitter.
// Ports: clk_i/rst_ni (sync, active-low), push_i/msg_i write side,
// pop_i read side, full_o/empty_o status, single_o (exactly one entry held),
// head_o (oldest entry, valid when !empty_o).
// Depth must be a power of two so the pointers wrap by natural overflow.
module ibex_noc_msg_fifo
  import ibex_noc_tx_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  noc_msg_t msg_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output logic     single_o,
  output noc_msg_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  noc_msg_t        mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            push_ok, pop_ok;

  assign full_o   = (count_q == DepthCnt);
  assign empty_o  = (count_q == '0);
  assign single_o = (count_q == (PtrW + 1)'(1));
  assign head_o   = mem_q[rptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= msg_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/ibex_noc_tx.sv
// Outbound NoC network interface for one Ibex hart.
// Accepts whole messages from the core (msg_if, req/gnt handshake), buffers
// them in a MsgDepth-entry FIFO and serialises each as one header flit plus
// len+1 payload flits on a 32-bit valid/ready link.
// Ports: clk_i, rst_ni (sync, active-low), hart_id_i (bits [4:0] = source),
// msg_if (slave side of the core message port), flit_valid_o/flit_ready_i/
// flit_data_o/flit_last_o (router link), tx_busy_o (work pending).
module ibex_noc_tx
  import ibex_noc_tx_pkg::*;
#(
  parameter int unsigned MsgDepth = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [31:0]   hart_id_i,
  ibex_noc_tx_if.slave  msg_if,
  output logic          flit_valid_o,
  input  logic          flit_ready_i,
  output logic [31:0]   flit_data_o,
  output logic          flit_last_o,
  output logic          tx_busy_o
);

  noc_tx_state_e state_q, state_d;
  logic [1:0]    beat_q, beat_d;

  noc_msg_t msg_in, head;
  logic     fifo_full, fifo_empty, fifo_single;
  logic     push, pop, handshake, last_beat;
  logic     unused_hart_id;

  assign unused_hart_id = ^hart_id_i[31:5];

  assign msg_in.core = msg_if.output_core;
  assign msg_in.addr = msg_if.output_addr;
  assign msg_in.len  = msg_if.len;
  assign msg_in.data = {msg_if.msg3_data, msg_if.msg2_data,
                        msg_if.msg1_data, msg_if.output_data};

  assign msg_if.noc_gnt = !fifo_full;
  assign push = msg_if.noc_req && !fifo_full;

  ibex_noc_msg_fifo #(
    .Depth (MsgDepth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (push),
    .msg_i    (msg_in),
    .pop_i    (pop),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .single_o (fifo_single),
    .head_o   (head)
  );

  assign flit_valid_o = (state_q != NocTxIdle);
  assign handshake    = flit_valid_o && flit_ready_i;
  assign last_beat    = (state_q == NocTxPayload) && (beat_q == head.len);
  assign pop          = handshake && last_beat;
  assign tx_busy_o    = !fifo_empty || (state_q != NocTxIdle);
  assign flit_last_o  = last_beat;

  always_comb begin
    flit_data_o = '0;
    unique case (state_q)
      NocTxHeader:  flit_data_o = noc_header(head, hart_id_i[4:0]);
      NocTxPayload: flit_data_o = head.data[beat_q];
      default:      flit_data_o = '0;
    endcase
  end

  // A push in the current cycle counts as "work remaining": the entry is
  // written at the same edge the FSM moves, so its header is on the link the
  // following cycle with no idle gap.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      NocTxIdle: begin
        if (!fifo_empty || push) begin
          state_d = NocTxHeader;
        end
      end
      NocTxHeader: begin
        if (handshake) begin
          state_d = NocTxPayload;
          beat_d  = '0;
        end
      end
      NocTxPayload: begin
        if (handshake) begin
          beat_d = beat_q + 2'd1;
          if (last_beat) begin
            state_d = (!fifo_single || push) ? NocTxHeader : NocTxIdle;
          end
        end
      end
      default: state_d = NocTxIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= NocTxIdle;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_ibex_noc_tx.sv
module tb_ibex_noc_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hart_id;
  logic        flit_ready;
  logic        flit_valid;
  logic [31:0] flit_data;
  logic        flit_last;
  logic        tx_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ibex_noc_tx_if nif ();

  ibex_noc_tx #(
    .MsgDepth (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .hart_id_i    (hart_id),
    .msg_if       (nif),
    .flit_valid_o (flit_valid),
    .flit_ready_i (flit_ready),
    .flit_data_o  (flit_data),
    .flit_last_o  (flit_last),
    .tx_busy_o    (tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_flit(input string tag, input logic [31:0] data, input logic last);
    check({tag, "_valid"}, {31'd0, flit_valid}, 32'd1);
    check({tag, "_data"}, flit_data, data);
    check({tag, "_last"}, {31'd0, flit_last}, {31'd0, last});
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_msg(input logic [1:0] len, input logic [4:0] core, input logic [4:0] addr,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    nif.len         = len;
    nif.output_core = core;
    nif.output_addr = addr;
    nif.output_data = d0;
    nif.msg1_data   = d1;
    nif.msg2_data   = d2;
    nif.msg3_data   = d3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] t2_exp [5];
  int          idx;

  initial begin
    rst_n      = 1'b0;
    flit_ready = 1'b0;
    hart_id    = 32'd1;
    nif.noc_req = 1'b0;
    set_msg(2'd0, 5'd0, 5'd0, '0, '0, '0, '0);

    // Reset state
    tick; tick; #1;
    check("rst_valid", {31'd0, flit_valid}, 32'd0);
    check("rst_last", {31'd0, flit_last}, 32'd0);
    check("rst_data", flit_data, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_gnt", {31'd0, nif.noc_gnt}, 32'd1);

    // Single message, no backpressure
    tick; rst_n = 1'b1; flit_ready = 1'b1;
    set_msg(2'd0, 5'd3, 5'd9, 32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333);
    nif.noc_req = 1'b1; #1;
    check("t1_gnt", {31'd0, nif.noc_gnt}, 32'd1);
    tick; nif.noc_req = 1'b0; #1;
    expect_flit("t1_hdr", 32'h1A408000, 1'b0);
    check("t1_busy", {31'd0, tx_busy}, 32'd1);
    tick; #1;
    expect_flit("t1_pay", 32'hDEADBEEF, 1'b1);
    tick; #1;
    check("t1_idle_valid", {31'd0, flit_valid}, 32'd0);
    check("t1_idle_busy", {31'd0, tx_busy}, 32'd0);

    // len=3 with ready pattern 1,0,0 repeating; upper hart id bits ignored
    tick; hart_id = 32'hFFFFFFE5;
    set_msg(2'd3, 5'd7, 5'd2, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3);
    nif.noc_req = 1'b1;
    t2_exp[0] = 32'h38B28000;
    t2_exp[1] = 32'hA0A0A0A0;
    t2_exp[2] = 32'hA1A1A1A1;
    t2_exp[3] = 32'hA2A2A2A2;
    t2_exp[4] = 32'hA3A3A3A3;
    tick; nif.noc_req = 1'b0;
    idx = 0;
    for (int c = 0; c < 30 && idx < 5; c++) begin
      flit_ready = ((c % 3) == 0);
      #1;
      expect_flit("t2_flit", t2_exp[idx], (idx == 4));
      if (flit_ready) idx++;
      tick;
    end
    check("t2_done", idx, 32'd5);
    #1;
    check("t2_idle", {31'd0, flit_valid}, 32'd0);

    // Fill with ready low: third request waits until one cycle after first pop
    tick; hart_id = 32'd1; flit_ready = 1'b0;
    set_msg(2'd0, 5'd1, 5'd1, 32'h0000000A, '0, '0, '0);
    nif.noc_req = 1'b1; #1;
    check("t3_gnt_a", {31'd0, nif.noc_gnt}, 32'd1);
    tick; set_msg(2'd0, 5'd2, 5'd2, 32'h0000000B, '0, '0, '0); #1;
    check("t3_gnt_b", {31'd0, nif.noc_gnt}, 32'd1);
    tick; set_msg(2'd0, 5'd4, 5'd4, 32'h0000000C, '0, '0, '0); #1;
    check("t3_gnt_full0", {31'd0, nif.noc_gnt}, 32'd0);
    expect_flit("t3_hdr_a_stall", 32'h08408000, 1'b0);
    tick; #1;
    check("t3_gnt_full1", {31'd0, nif.noc_gnt}, 32'd0);
    tick; flit_ready = 1'b1; #1;
    check("t3_gnt_full2", {31'd0, nif.noc_gnt}, 32'd0);
    expect_flit("t3_hdr_a", 32'h08408000, 1'b0);
    tick; #1;
    check("t3_gnt_popcyc", {31'd0, nif.noc_gnt}, 32'd0);
    expect_flit("t3_pay_a", 32'h0000000A, 1'b1);
    tick; #1;
    check("t3_gnt_after_pop", {31'd0, nif.noc_gnt}, 32'd1);
    expect_flit("t3_hdr_b", 32'h10808000, 1'b0);
    tick; nif.noc_req = 1'b0; #1;
    check("t3_gnt_refull", {31'd0, nif.noc_gnt}, 32'd0);
    expect_flit("t3_pay_b", 32'h0000000B, 1'b1);
    tick; #1;
    expect_flit("t3_hdr_c", 32'h21008000, 1'b0);
    tick; #1;
    expect_flit("t3_pay_c", 32'h0000000C, 1'b1);
    tick; #1;
    check("t3_idle_valid", {31'd0, flit_valid}, 32'd0);
    check("t3_idle_busy", {31'd0, tx_busy}, 32'd0);

    // Back-to-back len=1 messages, ready high: 6 flits with no bubble
    tick;
    set_msg(2'd1, 5'd31, 5'd31, 32'h00000100, 32'h00000101, '0, '0);
    nif.noc_req = 1'b1;
    tick; set_msg(2'd1, 5'd0, 5'd0, 32'h00000200, 32'h00000201, '0, '0); #1;
    expect_flit("t4_hdr1", 32'hFFD08000, 1'b0);
    tick; nif.noc_req = 1'b0; #1;
    expect_flit("t4_d10", 32'h00000100, 1'b0);
    tick; #1;
    expect_flit("t4_d11", 32'h00000101, 1'b1);
    tick; #1;
    expect_flit("t4_hdr2", 32'h00108000, 1'b0);
    tick; #1;
    expect_flit("t4_d20", 32'h00000200, 1'b0);
    tick; #1;
    expect_flit("t4_d21", 32'h00000201, 1'b1);
    tick; #1;
    check("t4_idle", {31'd0, flit_valid}, 32'd0);

    // Push coinciding with last-flit pop of a single held message
    tick;
    set_msg(2'd0, 5'd5, 5'd6, 32'h00000055, '0, '0, '0);
    nif.noc_req = 1'b1;
    tick; nif.noc_req = 1'b0; #1;
    expect_flit("t5_hdr1", 32'h29808000, 1'b0);
    tick; set_msg(2'd0, 5'd6, 5'd7, 32'h00000066, '0, '0, '0);
    nif.noc_req = 1'b1; #1;
    check("t5_gnt", {31'd0, nif.noc_gnt}, 32'd1);
    expect_flit("t5_pay1", 32'h00000055, 1'b1);
    tick; nif.noc_req = 1'b0; #1;
    expect_flit("t5_hdr2", 32'h31C08000, 1'b0);
    check("t5_gnt_count1", {31'd0, nif.noc_gnt}, 32'd1);
    tick; #1;
    expect_flit("t5_pay2", 32'h00000066, 1'b1);
    tick; #1;
    check("t5_idle_busy", {31'd0, tx_busy}, 32'd0);

    // Reset during payload beat 1 with a second message queued
    tick;
    set_msg(2'd2, 5'd9, 5'd3, 32'h00000091, 32'h00000092, 32'h00000093, '0);
    nif.noc_req = 1'b1;
    tick; set_msg(2'd0, 5'd10, 5'd1, 32'h000000A1, '0, '0, '0); #1;
    expect_flit("t6_hdr", 32'h48E08000, 1'b0);
    tick; nif.noc_req = 1'b0; #1;
    expect_flit("t6_b0", 32'h00000091, 1'b0);
    tick; rst_n = 1'b0; #1;
    expect_flit("t6_b1", 32'h00000092, 1'b0);
    tick; rst_n = 1'b1; #1;
    check("t6_rst_valid", {31'd0, flit_valid}, 32'd0);
    check("t6_rst_gnt", {31'd0, nif.noc_gnt}, 32'd1);
    check("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("t6_rst_data", flit_data, 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick; #1;
      check("t6_no_resend", {31'd0, flit_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
